qei_feedback_decoder: RTL and testbench
=======================================

Name: qei_feedback_decoder

Overview:
Quadrature encoder interface that produces the 16-bit `feedback` word consumed by `pid_controller`. It closes the loop from the plant side:
- Synchronizes and glitch-filters encoder pins A/B/Z.
- Performs x4 quadrature decode into a wrapping position counter.
- Publishes position and per-sample delta at the same `clk_prescaler` cadence the controller uses.

Parameters:
FILT_LEN, 3, consecutive stable cycles required before a filtered pin changes (legal 1..15)
SYNC_STAGES, 2, flip-flop synchronizer depth per encoder pin (legal 2..3)

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
enc_a  input  1  encoder channel A, asynchronous
enc_b  input  1  encoder channel B, asynchronous
enc_z  input  1  encoder index, asynchronous
clk_prescaler  input  16  sample period minus one, in clk cycles
count_clear  input  1  synchronous clear of position and error flag
feedback  output  16  sampled position, two's-complement, wraps
feedback_delta  output  16  feedback(new) minus feedback(previous), modulo 2^16
feedback_valid  output  1  one-cycle pulse when feedback and feedback_delta update
dir  output  1  direction of last legal step (1 = up)
err_illegal  output  1  sticky flag set on a double-bit AB transition

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs, position, prescaler counter, filter counters and synchronizers go to 0; FSM enters INIT.
- Synchronizer: SYNC_STAGES flip-flops per pin.
- Glitch filter: the filtered output takes a new synced value only after it is held for FILT_LEN consecutive cycles. Any bounce restarts the count.
- FSM, state INIT:
  - Filters track synced inputs directly.
  - Decoder loads prev_ab from filtered AB every cycle; no counting, no error detection.
  - Stays in INIT for SYNC_STAGES+FILT_LEN+1 cycles, then moves to RUN.
- FSM, state RUN: each cycle compares prev_ab with cur_ab.
  - Gray sequence 00→01→11→10→00: +1 step; the reverse sequence: −1 step; dir updates to match.
  - Equal states: no step.
  - Both bits changed: illegal. Position unchanged, err_illegal set, dir unchanged.
  - prev_ab ← cur_ab every cycle.
- Latency: pin edge → position register change = SYNC_STAGES+FILT_LEN+1 cycles (6 at defaults).
- Position arithmetic: 16-bit wrap (0x7FFF+1 = 0x8000; 0x0000−1 = 0xFFFF). No saturation.
- count_clear: the next position is 0 and err_illegal clears. Clear wins over a same-cycle step. FSM state is unaffected.
- Sampling: prescaler counter increments each cycle. When counter ≥ clk_prescaler:
  - Counter → 0.
  - feedback ← current position register (the value before any same-cycle step or clear).
  - feedback_delta ← that value minus the old feedback.
  - feedback_valid = 1 for that single cycle.
- clk_prescaler = 0 samples every cycle. Lowering clk_prescaler below the current count causes a sample on the next cycle.
- Sampling runs in both INIT and RUN.
- rst_n asserted mid-operation aborts everything in one cycle; no partial sample is emitted.

Optional Feature:
Macro QEI_INDEX_RESET_EN.
- Defined: a rising edge of filtered Z in RUN loads position 0 (same priority as count_clear; a same-cycle step is discarded).
- Not defined: enc_z is synchronized but ignored; position depends only on A/B and count_clear.

Decomposition:
- Package qei_pkg:
  - ab_t (logic [1:0]).
  - Enum step_e {STEP_NONE, STEP_UP, STEP_DN, STEP_ILLEGAL}.
  - Enum qei_state_e {QEI_INIT, QEI_RUN}.
  - Function decode_step(prev, cur) returning step_e.
- Sub-module qei_glitch_filter (sync + stability counter, parameters SYNC_STAGES/FILT_LEN, reset value 0), instantiated three times for A, B and Z.

Test Plan:
- Reset, A=B=0, clk_prescaler=9, no motion → feedback_valid pulses every 10 cycles; feedback=0, feedback_delta=0, err_illegal=0.
- Drive 8 forward Gray steps, each held 10 cycles → position=8, dir=1; the next sample gives feedback=8, feedback_delta=8. Then 3 reverse steps → feedback=5, delta=0xFFFD, dir=0.
- Start at position 0, one reverse step → feedback=0xFFFF; count_clear in the same cycle as a step edge → position=0.
- Toggle A from 00 directly to 11 with B in one edge (hold ≥ FILT_LEN) → err_illegal=1, position unchanged; count_clear → err_illegal=0.
- Pulse A for 2 cycles (< FILT_LEN=3) → no step, no error. Hold pins at 11 through reset release → no illegal flag (INIT primes prev_ab).
- With QEI_INDEX_RESET_EN, position=37, rising Z held 3 cycles → position=0; without the macro → position stays 37.

Source files
------------

// File: rtl/qei_pkg.sv
// rtl/qei_pkg.sv - shared types and quadrature step decode for qei_feedback_decoder
//
// Purpose: types shared by the decoder top and its pin filter, plus the
//          combinational AB transition classifier.
// Ports:   none (package).

package qei_pkg;

   // Encoder pin pair, bit 1 = channel A, bit 0 = channel B
   typedef logic [1:0] ab_t;

   typedef enum logic [1:0] {
      STEP_NONE,
      STEP_UP,
      STEP_DN,
      STEP_ILLEGAL
   } step_e;

   typedef enum logic {
      QEI_INIT,
      QEI_RUN
   } qei_state_e;

   // Forward Gray cycle is 00 -> 01 -> 11 -> 10 -> 00. Any single-bit change
   // that is not a forward move must be the reverse move.
   function automatic step_e decode_step(input ab_t prev, input ab_t cur);
      step_e s;
      if (prev == cur) begin
         s = STEP_NONE;
      end else if ((prev ^ cur) == 2'b11) begin
         s = STEP_ILLEGAL;
      end else begin
         case ({prev, cur})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: s = STEP_UP;
            default:                                s = STEP_DN;
         endcase
      end
      return s;
   endfunction

endpackage

// File: rtl/qei_glitch_filter.sv
// rtl/qei_glitch_filter.sv - per-pin synchronizer and stability filter
//
// Purpose: brings one asynchronous encoder pin into the clk domain and only
//          lets the filtered output follow it after FILT_LEN consecutive
//          cycles at the new level. A bounce back restarts the count.
// Ports:
//   i_clk     system clock
//   i_rst_n   synchronous active-low reset (chain, counter, output -> 0)
//   i_bypass  1 = filtered output follows the synced pin directly
//   i_pin     asynchronous pin
//   o_filt    filtered pin

module qei_glitch_filter
   import qei_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 3
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_bypass,
   input  logic i_pin,
   output logic o_filt
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [3:0]             r_cnt;
   logic                   r_filt;
   logic                   w_synced;

   assign w_synced = r_sync[SYNC_STAGES-1];
   assign o_filt   = r_filt;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_sync <= '0;
         r_cnt  <= '0;
         r_filt <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
         if (i_bypass || (w_synced == r_filt)) begin
            r_filt <= w_synced;
            r_cnt  <= '0;
         end else if (r_cnt == 4'(FILT_LEN - 1)) begin
            // this is the FILT_LEN-th consecutive cycle at the new level
            r_filt <= w_synced;
            r_cnt  <= '0;
         end else begin
            r_cnt <= r_cnt + 4'd1;
         end
      end
   end

endmodule

// File: rtl/qei_feedback_decoder.sv
// rtl/qei_feedback_decoder.sv - quadrature encoder decoder producing sampled feedback
//
// Purpose: filters encoder pins A/B/Z, decodes x4 quadrature into a wrapping
//          16-bit position and publishes position and per-sample delta every
//          clk_prescaler+1 cycles.
// Build option: QEI_INDEX_RESET_EN - when defined, a rising filtered Z in RUN
//          zeroes the position; otherwise Z is synchronized and ignored.
// Ports:
//   clk             system clock
//   rst_n           synchronous active-low reset
//   enc_a, enc_b    encoder channels, asynchronous
//   enc_z           encoder index, asynchronous
//   clk_prescaler   sample period minus one, in clk cycles
//   count_clear     synchronous clear of position and error flag
//   feedback        sampled position, two's complement, wraps
//   feedback_delta  feedback(new) - feedback(previous), modulo 2^16
//   feedback_valid  one-cycle pulse when feedback/feedback_delta update
//   dir             direction of last legal step (1 = up)
//   err_illegal     sticky flag, set on a double-bit AB transition

module qei_feedback_decoder
   import qei_pkg::*;
#(
   parameter int FILT_LEN    = 3,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enc_a,
   input  logic        enc_b,
   input  logic        enc_z,
   input  logic [15:0] clk_prescaler,
   input  logic        count_clear,
   output logic [15:0] feedback,
   output logic [15:0] feedback_delta,
   output logic        feedback_valid,
   output logic        dir,
   output logic        err_illegal
);

   // INIT lasts long enough for a pin level present at reset release to
   // reach the filter outputs and be captured as prev_ab.
   localparam int INIT_CYCLES = SYNC_STAGES + FILT_LEN + 1;

   qei_state_e  r_state;
   qei_state_e  w_state_next;
   logic [4:0]  r_init_cnt;
   logic        w_run;

   logic        w_a_filt;
   logic        w_b_filt;
   logic        w_z_filt;
   ab_t         w_cur_ab;
   ab_t         r_prev_ab;
   step_e       w_step;
   logic        w_index_load;

   logic [15:0] r_pos;
   logic [15:0] w_pos_next;
   logic        r_dir;
   logic        w_dir_next;
   logic        r_err;
   logic        w_err_next;

   logic [15:0] r_pre_cnt;
   logic [15:0] r_feedback;
   logic [15:0] r_delta;
   logic        r_valid;

   assign w_run = (r_state == QEI_RUN);

   qei_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_bypass(!w_run), .i_pin(enc_a), .o_filt(w_a_filt)
   );

   qei_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_bypass(!w_run), .i_pin(enc_b), .o_filt(w_b_filt)
   );

   qei_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_z (
      .i_clk(clk), .i_rst_n(rst_n), .i_bypass(!w_run), .i_pin(enc_z), .o_filt(w_z_filt)
   );

   assign w_cur_ab = {w_a_filt, w_b_filt};

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= QEI_INIT;
         r_init_cnt <= '0;
      end else begin
         r_state <= w_state_next;
         if (!w_run) begin
            r_init_cnt <= r_init_cnt + 5'd1;
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         QEI_INIT: begin
            if (r_init_cnt == 5'(INIT_CYCLES - 1)) begin
               w_state_next = QEI_RUN;
            end
         end
         QEI_RUN: begin
            w_state_next = QEI_RUN;
         end
         default: begin
            w_state_next = QEI_INIT;
         end
      endcase
   end

   // ----------------------------------------------------- index handling
`ifdef QEI_INDEX_RESET_EN
   logic r_z_prev;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_z_prev <= 1'b0;
      end else begin
         r_z_prev <= w_z_filt;
      end
   end

   assign w_index_load = w_run && w_z_filt && !r_z_prev;
`else
   logic w_unused_z;

   assign w_unused_z   = w_z_filt;
   assign w_index_load = 1'b0;
`endif

   // ------------------------------------------------------------ decoder
   always_comb begin
      w_step     = decode_step(r_prev_ab, w_cur_ab);
      w_pos_next = r_pos;
      w_dir_next = r_dir;
      w_err_next = r_err;
      if (w_run) begin
         case (w_step)
            STEP_UP: begin
               w_pos_next = r_pos + 16'd1;
               w_dir_next = 1'b1;
            end
            STEP_DN: begin
               w_pos_next = r_pos - 16'd1;
               w_dir_next = 1'b0;
            end
            STEP_ILLEGAL: begin
               w_err_next = 1'b1;
            end
            default: begin
               w_pos_next = r_pos;
            end
         endcase
      end
      // zeroing discards any same-cycle step
      if (w_index_load) begin
         w_pos_next = '0;
      end
      if (count_clear) begin
         w_pos_next = '0;
         w_err_next = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_prev_ab <= '0;
         r_pos     <= '0;
         r_dir     <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_prev_ab <= w_cur_ab;
         r_pos     <= w_pos_next;
         r_dir     <= w_dir_next;
         r_err     <= w_err_next;
      end
   end

   // ----------------------------------------------------------- sampling
   // >= rather than == so that lowering clk_prescaler below the running
   // count forces a sample on the next cycle instead of a 2^16 wrap.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pre_cnt  <= '0;
         r_feedback <= '0;
         r_delta    <= '0;
         r_valid    <= 1'b0;
      end else if (r_pre_cnt >= clk_prescaler) begin
         r_pre_cnt  <= '0;
         r_feedback <= r_pos;
         r_delta    <= r_pos - r_feedback;
         r_valid    <= 1'b1;
      end else begin
         r_pre_cnt  <= r_pre_cnt + 16'd1;
         r_valid    <= 1'b0;
      end
   end

   assign feedback       = r_feedback;
   assign feedback_delta = r_delta;
   assign feedback_valid = r_valid;
   assign dir            = r_dir;
   assign err_illegal    = r_err;

endmodule

// File: tb/tb_qei_feedback_decoder.sv
// tb/tb_qei_feedback_decoder.sv - self-checking bench for qei_feedback_decoder

module tb_qei_feedback_decoder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enc_a = 1'b0;
   logic        enc_b = 1'b0;
   logic        enc_z = 1'b0;
   logic [15:0] clk_prescaler = 16'd9;
   logic        count_clear = 1'b0;
   logic [15:0] feedback;
   logic [15:0] feedback_delta;
   logic        feedback_valid;
   logic        dir;
   logic        err_illegal;

   always #5 clk = ~clk;

   qei_feedback_decoder dut (
      .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .enc_z(enc_z),
      .clk_prescaler(clk_prescaler), .count_clear(count_clear),
      .feedback(feedback), .feedback_delta(feedback_delta),
      .feedback_valid(feedback_valid), .dir(dir), .err_illegal(err_illegal)
   );

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   // Reference model: pins sit at index gp of the Gray cycle; the encoder's
   // position is the signed count of cycle steps taken since the last zero.
   int          gp    = 0;
   logic [15:0] m_pos = 16'd0;
   logic [15:0] m_fb  = 16'd0;
   logic        m_dir = 1'b0;
   logic        m_err = 1'b0;

   function automatic logic [1:0] gray_of(input int i);
      case (i)
         0:       return 2'b00;
         1:       return 2'b01;
         2:       return 2'b11;
         default: return 2'b10;
      endcase
   endfunction

   task automatic chk(input string tag, input string what, input logic [15:0] obs, input logic [15:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s.%s observed=0x%04h expected=0x%04h", tag, what, obs, exp);
      end
   endtask

   task automatic drive_pins();
      logic [1:0] v;
      v = gray_of(gp);
      enc_a = v[1];
      enc_b = v[0];
   endtask

   task automatic step(input int d, input int hold);
      gp = (gp + d + 4) % 4;
      drive_pins();
      if (d > 0) begin
         m_pos = m_pos + 16'd1;
         m_dir = 1'b1;
      end else begin
         m_pos = m_pos - 16'd1;
         m_dir = 1'b0;
      end
      repeat (hold) @(negedge clk);
   endtask

   task automatic clear_pulse();
      count_clear = 1'b1;
      @(negedge clk);
      count_clear = 1'b0;
      m_pos = 16'd0;
      m_err = 1'b0;
   endtask

   // Waits (bounded) for the next sample pulse and checks it against the model.
   task automatic sample_check(input string tag);
      int k;
      k = 0;
      while (feedback_valid !== 1'b1 && k < 400) begin
         @(negedge clk);
         k++;
      end
      chk(tag, "valid_seen", 16'(feedback_valid), 16'd1);
      chk(tag, "feedback", feedback, m_pos);
      chk(tag, "delta", feedback_delta, m_pos - m_fb);
      chk(tag, "dir", 16'(dir), 16'(m_dir));
      chk(tag, "err", 16'(err_illegal), 16'(m_err));
      m_fb = m_pos;
      @(negedge clk);
   endtask

   initial begin
      int k;
      int n;

      // reset state
      repeat (3) @(negedge clk);
      chk("reset", "feedback", feedback, 16'd0);
      chk("reset", "delta", feedback_delta, 16'd0);
      chk("reset", "valid", 16'(feedback_valid), 16'd0);
      chk("reset", "dir", 16'(dir), 16'd0);
      chk("reset", "err", 16'(err_illegal), 16'd0);

      // prescaler 9: first sample 10 cycles after release, then every 10
      rst_n = 1'b1;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (feedback_valid !== 1'b1 && k < 50);
      chk("ps9", "first_latency", 16'(k), 16'd10);
      chk("ps9", "feedback", feedback, 16'd0);
      chk("ps9", "delta", feedback_delta, 16'd0);
      for (int p = 0; p < 2; p++) begin
         k = 0;
         do begin
            @(negedge clk);
            k++;
         end while (feedback_valid !== 1'b1 && k < 50);
         chk("ps9", "period", 16'(k), 16'd10);
      end

      // prescaler 0: a sample every cycle
      clk_prescaler = 16'd0;
      for (int p = 0; p < 5; p++) begin
         @(negedge clk);
         chk("ps0", "valid", 16'(feedback_valid), 16'd1);
      end

      // long period so each motion burst lands between two checked samples
      clk_prescaler = 16'd199;
      sample_check("align");

      for (int i = 0; i < 8; i++) step(1, 10);
      sample_check("fwd8");
      for (int i = 0; i < 3; i++) step(-1, 10);
      sample_check("rev3");

      clear_pulse();
      sample_check("clear");
      step(-1, 10);
      sample_check("wrap_dn");

      // clear lands on the cycle the step reaches the position register
      gp = (gp + 3) % 4;
      drive_pins();
      repeat (5) @(negedge clk);
      count_clear = 1'b1;
      @(negedge clk);
      count_clear = 1'b0;
      m_pos = 16'd0;
      m_err = 1'b0;
      repeat (4) @(negedge clk);
      sample_check("clr_step");

      // double-bit transition
      step(1, 10);
      step(1, 10);
      gp = (gp + 2) % 4;
      drive_pins();
      m_err = 1'b1;
      repeat (10) @(negedge clk);
      sample_check("illegal");
      clear_pulse();
      sample_check("ill_clr");

      // 2-cycle pulse on A is shorter than the filter length
      enc_a = ~enc_a;
      repeat (2) @(negedge clk);
      enc_a = ~enc_a;
      repeat (10) @(negedge clk);
      sample_check("glitch");

      // lowering the period below the running count forces a sample next cycle
      repeat (50) @(negedge clk);
      clk_prescaler = 16'd10;
      @(negedge clk);
      chk("lower_ps", "valid", 16'(feedback_valid), 16'd1);
      chk("lower_ps", "feedback", feedback, m_pos);
      clk_prescaler = 16'd199;
      m_fb = m_pos;
      @(negedge clk);

      // random motion bursts
      for (int b = 0; b < 6; b++) begin
         n = int'($urandom_range(1, 10));
         for (int i = 0; i < n; i++) begin
            step(($urandom % 2) ? 1 : -1, int'($urandom_range(4, 12)));
         end
         sample_check("rand");
      end

      // pins held at 11 through reset: INIT must prime prev_ab
      gp = 2;
      drive_pins();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst11", "feedback", feedback, 16'd0);
      chk("rst11", "err", 16'(err_illegal), 16'd0);
      rst_n = 1'b1;
      m_pos = 16'd0;
      m_fb  = 16'd0;
      m_dir = 1'b0;
      m_err = 1'b0;
      repeat (20) @(negedge clk);
      step(1, 10);
      sample_check("rst11_run");

      // index pulse at position 37
      clear_pulse();
      sample_check("pre37");
      for (int i = 0; i < 37; i++) step(1, 4);
      sample_check("pos37");
      enc_z = 1'b1;
      repeat (3) @(negedge clk);
      enc_z = 1'b0;
`ifdef QEI_INDEX_RESET_EN
      m_pos = 16'd0;
`endif
      repeat (10) @(negedge clk);
      sample_check("index");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
